// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU and a secondary
// (ext) master. One access is granted per cycle. The CPU has fixed priority, and
// a starvation counter forces the ext master ahead after STARVE_LIMIT denied
// cycles. Read data is returned to the master that issued the read, using a tag
// pipe that matches the RAM read latency.
// Optional feature: define DMEM_ARB_LOCK_EN so that ext_lock holds ext ownership
// for bursts. When the macro is not defined, ext_lock is ignored.
module dmem_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        CPU_PRI = 1'b0,
        EXT_PRI = 1'b1
    } arb_state_e;

    arb_state_e             state_r;
    arb_state_e             state_next_s;
    logic [CNT_W-1:0]       starve_cnt_r;
    logic [CNT_W-1:0]       starve_cnt_next_s;
    logic                   cpu_gnt_s;
    logic                   ext_gnt_s;
    logic                   ext_denied_s;
    logic                   lock_active_s;
    logic                   rd_issue_s;
    logic [RD_LATENCY-1:0]  rd_valid_pipe_r;
    logic [RD_LATENCY-1:0]  rd_owner_pipe_r;
    logic                   cpu_rvalid_s;
    logic                   ext_rvalid_s;
    logic [DATA_W-1:0]      cpu_rdata_r;
    logic [DATA_W-1:0]      ext_rdata_r;

`ifdef DMEM_ARB_LOCK_EN
    logic lock_own_r;

    // Ext takes ownership when granted with ext_lock high and keeps it until ext_lock falls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_own_r <= 1'b0;
        end else if (!ext_lock) begin
            lock_own_r <= 1'b0;
        end else if (ext_gnt_s) begin
            lock_own_r <= 1'b1;
        end else begin
            lock_own_r <= lock_own_r;
        end
    end

    assign lock_active_s = lock_own_r & ext_lock;
`else
    logic unused_lock_s;
    assign unused_lock_s = ext_lock;
    assign lock_active_s = 1'b0;
`endif

    // Priority state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= CPU_PRI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant decode: one-hot or none. Grants are suppressed while reset is asserted.
    always_comb begin
        cpu_gnt_s = 1'b0;
        ext_gnt_s = 1'b0;
        if (!reset) begin
            cpu_gnt_s = 1'b0;
            ext_gnt_s = 1'b0;
        end else if (lock_active_s) begin
            ext_gnt_s = ext_req;
        end else begin
            case (state_r)
                CPU_PRI: begin
                    if (cpu_req) begin
                        cpu_gnt_s = 1'b1;
                    end else begin
                        ext_gnt_s = ext_req;
                    end
                end
                EXT_PRI: begin
                    if (ext_req) begin
                        ext_gnt_s = 1'b1;
                    end else begin
                        cpu_gnt_s = cpu_req;
                    end
                end
                default: begin
                    cpu_gnt_s = 1'b0;
                    ext_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Starvation counter next value: count denied ext cycles (saturating), clear on ext grant, freeze while locked.
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        ext_denied_s      = ext_req & ~ext_gnt_s;
        if (lock_active_s) begin
            starve_cnt_next_s = starve_cnt_r;
        end else if (ext_gnt_s) begin
            starve_cnt_next_s = {CNT_W{1'b0}};
        end else if (ext_denied_s && (starve_cnt_r < STARVE_MAX)) begin
            starve_cnt_next_s = starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // Next priority state. Ext gets priority once denial reaches the limit and gives it back after one grant.
    always_comb begin
        state_next_s = state_r;
        if (lock_active_s) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                CPU_PRI: begin
                    if (ext_denied_s && (starve_cnt_next_s == STARVE_MAX)) begin
                        state_next_s = EXT_PRI;
                    end else begin
                        state_next_s = CPU_PRI;
                    end
                end
                EXT_PRI: begin
                    if (ext_gnt_s || cpu_gnt_s) begin
                        state_next_s = CPU_PRI;
                    end else begin
                        state_next_s = EXT_PRI;
                    end
                end
                default: begin
                    state_next_s = CPU_PRI;
                end
            endcase
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // RAM port mux: the granted master drives the RAM. With no grant, the port is parked at zero.
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = {ADDR_W{1'b0}};
        ram_dataIn = {DATA_W{1'b0}};
        if (cpu_gnt_s) begin
            ram_wEn    = cpu_we;
            ram_addr   = cpu_addr;
            ram_dataIn = cpu_wdata;
        end else if (ext_gnt_s) begin
            ram_wEn    = ext_we;
            ram_addr   = ext_addr;
            ram_dataIn = ext_wdata;
        end else begin
            ram_wEn    = 1'b0;
            ram_addr   = {ADDR_W{1'b0}};
            ram_dataIn = {DATA_W{1'b0}};
        end
    end

    assign rd_issue_s = (cpu_gnt_s & ~cpu_we) | (ext_gnt_s & ~ext_we);

    // Read tag pipe: {valid, owner} travels alongside the RAM read latency. Owner value 1 means ext.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid_pipe_r <= {RD_LATENCY{1'b0}};
            rd_owner_pipe_r <= {RD_LATENCY{1'b0}};
        end else begin
            rd_valid_pipe_r[0] <= rd_issue_s;
            rd_owner_pipe_r[0] <= ext_gnt_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_valid_pipe_r[i] <= rd_valid_pipe_r[i-1];
                rd_owner_pipe_r[i] <= rd_owner_pipe_r[i-1];
            end
        end
    end

    assign cpu_rvalid_s = rd_valid_pipe_r[RD_LATENCY-1] & ~rd_owner_pipe_r[RD_LATENCY-1];
    assign ext_rvalid_s = rd_valid_pipe_r[RD_LATENCY-1] &  rd_owner_pipe_r[RD_LATENCY-1];

    // Per-master read data holding registers. Only the owning master's register is updated.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_rdata_r <= {DATA_W{1'b0}};
            ext_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if (cpu_rvalid_s) begin
                cpu_rdata_r <= ram_dataOut;
            end else begin
                cpu_rdata_r <= cpu_rdata_r;
            end
            if (ext_rvalid_s) begin
                ext_rdata_r <= ram_dataOut;
            end else begin
                ext_rdata_r <= ext_rdata_r;
            end
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign ext_gnt    = ext_gnt_s;
    assign cpu_rvalid = cpu_rvalid_s;
    assign ext_rvalid = ext_rvalid_s;
    assign cpu_rdata  = cpu_rvalid_s ? ram_dataOut : cpu_rdata_r;
    assign ext_rdata  = ext_rvalid_s ? ram_dataOut : ext_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. It contains a behavioural RAM, a priority/starvation
// reference model, and a read-response scoreboard that a separate monitor process
// checks.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_lock, ext_gnt, ext_rvalid;
    logic [11:0] ext_addr;
    logic [31:0] ext_wdata, ext_rdata;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn, ram_dataOut;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always #5 clock = ~clock;

    // Behavioural single-port RAM with one cycle of read latency.
    logic [31:0] ram_mem [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram_mem[ram_addr];
    end

    typedef struct {
        bit          owner;   // 0 = cpu, 1 = ext
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cpu_last = 32'd0;
    logic [31:0] exp_ext_last = 32'd0;

    // Reference model state
    logic [31:0] m_mem [0:4095];
    int          m_denied;
    bit          m_ext_turn;
    bit          m_lock_own;
    bit          m_cg, m_eg;
    bit          dut_eg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_denied     = 0;
        m_ext_turn   = 1'b0;
        m_lock_own   = 1'b0;
        exp_q.delete();
        exp_cpu_last = 32'd0;
        exp_ext_last = 32'd0;
    endtask

    // Drive one cycle of requests, check the grant and the RAM port against the model, then advance the model.
    task automatic step(input bit wait_edge,
                        input bit c_req, input bit c_we, input logic [11:0] c_addr, input logic [31:0] c_wd,
                        input bit e_req, input bit e_we, input logic [11:0] e_addr, input logic [31:0] e_wd,
                        input bit e_lk);
        bit          lock_act;
        bit          exp_we;
        logic [11:0] exp_addr;
        logic [31:0] exp_wd;
        exp_t        e;
        if (wait_edge) @(negedge clock);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        ext_req = e_req; ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wd; ext_lock = e_lk;
        #1;
        lock_act = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        lock_act = m_lock_own && e_lk;
`endif
        if (lock_act) begin
            m_eg = e_req; m_cg = 1'b0;
        end else if (c_req && e_req) begin
            m_eg = m_ext_turn; m_cg = !m_ext_turn;
        end else begin
            m_cg = c_req; m_eg = e_req;
        end
        exp_we = 1'b0; exp_addr = 12'd0; exp_wd = 32'd0;
        if (m_cg) begin exp_we = c_we; exp_addr = c_addr; exp_wd = c_wd; end
        if (m_eg) begin exp_we = e_we; exp_addr = e_addr; exp_wd = e_wd; end
        dut_eg = ext_gnt;
        chk("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, m_cg});
        chk("ext_gnt", {31'd0, ext_gnt}, {31'd0, m_eg});
        chk("ram_wEn", {31'd0, ram_wEn}, {31'd0, exp_we});
        chk("ram_addr", {20'd0, ram_addr}, {20'd0, exp_addr});
        chk("ram_dataIn", ram_dataIn, exp_wd);
        if (m_cg || m_eg) begin
            if (exp_we) begin
                m_mem[exp_addr] = exp_wd;
            end else begin
                e.owner = m_eg;
                e.data  = m_mem[exp_addr];
                exp_q.push_back(e);
            end
        end
        if (!lock_act) begin
            if (m_eg) begin
                m_denied = 0; m_ext_turn = 1'b0;
            end else if (e_req) begin
                if (m_denied < 4) m_denied++;
                if (m_denied == 4) m_ext_turn = 1'b1;
            end else if (m_cg) begin
                m_ext_turn = 1'b0;
            end
        end
        if (m_eg && e_lk) m_lock_own = 1'b1;
        else if (!e_lk) m_lock_own = 1'b0;
    endtask

    // Monitor: pop the expected response whenever read data is presented, and check that idle rdata holds its value.
    always @(negedge clock) begin
        exp_t e;
        if (cpu_rvalid && ext_rvalid) chk("rvalid_onehot", 32'd1, 32'd0);
        if (cpu_rvalid || ext_rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", {31'd0, ext_rvalid}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rd_owner", {31'd0, ext_rvalid}, {31'd0, e.owner});
                if (e.owner) exp_ext_last = e.data;
                else         exp_cpu_last = e.data;
            end
        end
        chk("cpu_rdata", cpu_rdata, exp_cpu_last);
        chk("ext_rdata", ext_rdata, exp_ext_last);
    end

    initial begin
        bit          c_pend, c_we_r, e_pend, e_we_r, e_lk;
        logic [11:0] c_ad, e_ad;
        logic [31:0] c_wd_r, e_wd_r;
        int          ext_cnt, first_ext;

        clock = 1'b0;
        reset = 1'b0;
        model_reset();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h005; cpu_wdata = 32'h1234_5678;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h006; ext_wdata = 32'h8765_4321; ext_lock = 1'b0;

        // Reset held with both requests active: nothing is granted.
        repeat (3) @(negedge clock);
        chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        chk("rst_ext_gnt", {31'd0, ext_gnt}, 32'd0);
        chk("rst_ram_wEn", {31'd0, ram_wEn}, 32'd0);
        chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        chk("rst_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);
        reset = 1'b1;
        // Release: the CPU is granted in the same cycle.
        step(1'b0, 1'b1, 1'b1, 12'h005, 32'h1234_5678, 1'b1, 1'b1, 12'h006, 32'h8765_4321, 1'b0);

        // Preload addresses 0..15 so that random reads return known data.
        for (int a = 0; a < 16; a++)
            step(1'b1, 1'b1, 1'b1, 12'(a), $urandom, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);

        // CPU write then read at 0x010.
        step(1'b1, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'h010, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        chk("t2_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("t2_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t2_ext_rvalid", {31'd0, ext_rvalid}, 32'd0);

        // Interleaved reads from ext and then cpu.
        step(1'b1, 1'b1, 1'b1, 12'h020, 32'h0000_0011, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 12'h021, 32'h0000_0022, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 12'h020, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 12'h021, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        chk("t4_ext_rvalid", {31'd0, ext_rvalid}, 32'd1);
        chk("t4_ext_rdata", ext_rdata, 32'h0000_0011);
        step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        chk("t4_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
        chk("t4_cpu_rdata", cpu_rdata, 32'h0000_0022);
        chk("t4_ext_rdata_hold", ext_rdata, 32'h0000_0011);

        // Reset right after a granted CPU read: the in-flight read is dropped.
        step(1'b1, 1'b1, 1'b0, 12'h010, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
            chk("t5_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
        end
        chk("t5_cpu_rdata", cpu_rdata, 32'd0);

        // Continuous contention starting from fresh state, with ext_lock held high.
        ext_cnt = 0; first_ext = -1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 1'b0, 12'($urandom_range(0, 15)), 32'd0,
                 1'b1, 1'b0, 12'($urandom_range(0, 15)), 32'd0, 1'b1);
            if (dut_eg) begin
                ext_cnt++;
                if (first_ext < 0) first_ext = k;
            end
        end
`ifdef DMEM_ARB_LOCK_EN
        chk("t3_ext_count", 32'(ext_cnt), 32'd16);
`else
        chk("t3_ext_count", 32'(ext_cnt), 32'd4);
`endif
        chk("t3_first_ext", 32'(first_ext), 32'd4);
        step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);

        // Randomized traffic: each master holds its request until it is granted.
        c_pend = 1'b0; e_pend = 1'b0;
        c_we_r = 1'b0; e_we_r = 1'b0; c_ad = 12'd0; e_ad = 12'd0; c_wd_r = 32'd0; e_wd_r = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            if (!c_pend) begin
                c_pend = ($urandom_range(0, 3) != 0);
                c_we_r = 1'($urandom_range(0, 1));
                c_ad   = 12'($urandom_range(0, 15));
                c_wd_r = $urandom;
            end
            if (!e_pend) begin
                e_pend = ($urandom_range(0, 3) != 0);
                e_we_r = 1'($urandom_range(0, 1));
                e_ad   = 12'($urandom_range(0, 15));
                e_wd_r = $urandom;
            end
            e_lk = ($urandom_range(0, 7) == 0);
            step(1'b1, c_pend, c_we_r, c_ad, c_wd_r, e_pend, e_we_r, e_ad, e_wd_r, e_lk);
            if (m_cg) c_pend = 1'b0;
            if (m_eg) e_pend = 1'b0;
        end

        // Drain the outstanding reads.
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0, 1'b0, 12'd0, 32'd0, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
